// File: rtl/aemb_pkg.sv
// Shared constants for the AEMB fetch/decode path: opcodes, interrupt vector and link register.
package aemb_pkg;

  localparam logic [5:0]  OPC_IMM = 6'o54;
  localparam logic [5:0]  OPC_BRU = 6'o56;
  localparam logic [15:0] XCE_VEC = 16'h0010;
  localparam logic [4:0]  LNK_REG = 5'd14;
  localparam logic [4:0]  XCE_RA  = 5'h0C;
  localparam logic [1:0]  XCE_INT = 2'o1;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/aemb_ibuf_skid.sv
// One-entry holding register for a fetched instruction word that could not be consumed.
module aemb_ibuf_skid (
  input  logic        gclk,
  input  logic        grst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] din,
  output logic        valid,
  output logic [31:0] dat
);

  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      valid <= 1'b0;
      dat   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dat   <= din;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/aemb_ibuf.sv
// AEMB instruction buffer: skid-buffered fetch, field decode, IMM prefix handling.
// Define AEMB_XCE_INJECT_EN to enable interrupt instruction injection via rXCE.
module aemb_ibuf
  import aemb_pkg::*;
(
  input  logic        gclk,
  input  logic        grst,
  input  logic        gena,
  input  logic [31:0] iwb_dat_i,
  input  logic        iwb_ack_i,
  output logic        iwb_stb_o,
  input  logic        rBRA,
  input  logic        rDLY,
  input  logic [1:0]  rXCE,
  output logic [5:0]  rOPC,
  output logic [4:0]  rRD,
  output logic [4:0]  rRA,
  output logic [4:0]  rRB,
  output logic [10:0] rALT,
  output logic [15:0] rIMM,
  output logic [31:0] rSIMM,
  output logic        rSTALL
);

  logic        skv;
  logic [31:0] skd;
  logic [31:0] src;
  logic        load;
  logic        ack_ok;
  logic        skd_load;
  logic        skd_clr;
  logic        pfx_v;
  logic [31:0] simm_nxt;
  logic        rIMMV;
  logic [15:0] rIMMHI;

  assign iwb_stb_o = !skv;
  assign rSTALL    = !(skv | iwb_ack_i);
  assign src       = skv ? skd : iwb_dat_i;
  assign load      = gena & !rSTALL;
  // Ack only counts while a request is outstanding, i.e. the skid is empty.
  assign ack_ok    = iwb_ack_i & !skv;

`ifdef AEMB_XCE_INJECT_EN
  logic inject;
  assign inject   = load & (rXCE == XCE_INT);
  assign skd_load = ack_ok & (!gena | inject);
  assign skd_clr  = load & !inject;
`else
  logic unused_xce;
  assign unused_xce = ^rXCE;
  assign skd_load   = ack_ok & !gena;
  assign skd_clr    = load;
`endif

  aemb_ibuf_skid u_skid (
    .gclk  (gclk),
    .grst  (grst),
    .load  (skd_load),
    .clear (skd_clr),
    .din   (iwb_dat_i),
    .valid (skv),
    .dat   (skd)
  );

  always_comb begin
    // A taken branch without delay slot kills any pending prefix.
    pfx_v    = rIMMV & !(rBRA & !rDLY);
    simm_nxt = pfx_v ? {rIMMHI, src[15:0]} : sext16(src[15:0]);
  end

  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      rOPC   <= '0;
      rRD    <= '0;
      rRA    <= '0;
      rRB    <= '0;
      rALT   <= '0;
      rIMM   <= '0;
      rSIMM  <= '0;
      rIMMV  <= 1'b0;
      rIMMHI <= '0;
    end else if (load) begin
`ifdef AEMB_XCE_INJECT_EN
      if (inject) begin
        rOPC  <= OPC_BRU;
        rRD   <= LNK_REG;
        rRA   <= XCE_RA;
        rRB   <= '0;
        rALT  <= XCE_VEC[10:0];
        rIMM  <= XCE_VEC;
        rSIMM <= sext16(XCE_VEC);
        rIMMV <= 1'b0;
      end else begin
`else
      begin
`endif
        rOPC  <= src[31:26];
        rRD   <= src[25:21];
        rRA   <= src[20:16];
        rRB   <= src[15:11];
        rALT  <= src[10:0];
        rIMM  <= src[15:0];
        rSIMM <= simm_nxt;
        rIMMV <= (src[31:26] == OPC_IMM);
        if (src[31:26] == OPC_IMM) begin
          rIMMHI <= src[15:0];
        end
      end
    end
  end

endmodule
